// File: rtl/ecc_mem_scrubber.sv
// Background SECDED scrubber: walks every word, rewrites single-bit
// errors with the corrected codeword, logs uncorrectable ones.
module ecc_mem_scrubber #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [38:0]       mem_wdata,
  input  logic [38:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err_valid,
  output logic              err_type,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_WR_REQ  = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  // Hamming position of data bit k (non-powers-of-two from 3 to 38)
  localparam logic [5:0] POS [32] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [38:0]       r_word;
  logic [38:0]       r_wdata;
  logic [ADDR_W-1:0] r_err_addr;
  logic [CNT_W-1:0]  r_corr;
  logic [CNT_W-1:0]  r_uncorr;

  logic [5:0]  w_calc;
  logic [5:0]  w_syn;
  logic        w_pe;
  logic        w_single;
  logic        w_uncorr;
  logic        w_chk;
  logic [38:0] w_mask;

  always_comb begin
    w_calc = '0;
    for (int k = 0; k < 32; k++) begin
      if (r_word[k]) w_calc = w_calc ^ POS[k];
    end
  end

  assign w_syn = w_calc ^ r_word[37:32];
  assign w_pe  = ^r_word;

  // pe=1 with s<=38 names exactly one bit; everything else is uncorrectable
  assign w_single = w_pe && (w_syn <= 6'd38);
  assign w_uncorr = w_pe ? (w_syn > 6'd38) : (w_syn != 6'd0);

  always_comb begin
    w_mask = '0;
    if (w_syn == 6'd0) w_mask[38] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (w_syn == (6'd1 << i)) w_mask[32+i] = 1'b1;
    end
    for (int k = 0; k < 32; k++) begin
      if (w_syn == POS[k]) w_mask[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_word     <= '0;
      r_wdata    <= '0;
      r_err_addr <= '0;
      r_corr     <= '0;
      r_uncorr   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_corr   <= '0;
            r_uncorr <= '0;
            r_addr   <= '0;
            r_state  <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (mem_gnt) r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_word  <= mem_rdata;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_single) begin
            r_wdata    <= r_word ^ w_mask;
            r_err_addr <= r_addr;
            if (r_corr != '1) r_corr <= r_corr + 1'b1;
            r_state    <= S_WR_REQ;
          end else if (w_uncorr) begin
            r_err_addr <= r_addr;
            if (r_uncorr != '1) r_uncorr <= r_uncorr + 1'b1;
            r_state    <= S_NEXT;
          end else begin
            r_state <= S_NEXT;
          end
        end
        S_WR_REQ: begin
          if (mem_gnt) r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (r_addr == ADDR_W'(DEPTH - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_RD_REQ;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_chk = (r_state == S_CHECK);

  assign mem_req      = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
  assign mem_we       = (r_state == S_WR_REQ);
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign err_valid    = w_chk && (w_single || w_uncorr);
  assign err_type     = w_chk && w_uncorr;
  assign err_addr     = err_valid ? r_addr : r_err_addr;
  assign corr_count   = r_corr;
  assign uncorr_count = r_uncorr;

endmodule

// File: tb/tb_ecc_mem_scrubber.sv
// Directed and randomized scrubber passes against a memory model and
// a flip-count reference: 1 flip = corrected, 2 flips = uncorrectable.
module tb_ecc_mem_scrubber;

  localparam int AW = 6;
  localparam int N  = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mem_req;
  logic          mem_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [38:0]   mem_wdata;
  logic [38:0]   mem_rdata;
  logic          busy;
  logic          done;
  logic          err_valid;
  logic          err_type;
  logic [AW-1:0] err_addr;
  logic [CW-1:0] corr_count;
  logic [CW-1:0] uncorr_count;

  ecc_mem_scrubber #(.ADDR_W(AW), .DEPTH(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err_valid(err_valid),
    .err_type(err_type), .err_addr(err_addr),
    .corr_count(corr_count), .uncorr_count(uncorr_count)
  );

  always #5 clk = ~clk;

  logic [38:0] mem   [N];
  logic [38:0] pre   [N];
  logic [31:0] orig  [N];
  int          nflip [N];
  int          wr_q[$];
  int          ev_type[$];
  int          ev_addr[$];
  int          cyc = 0;
  int          we_bad = 0;
  int          t0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_q.push_back(int'(mem_addr));
      end else begin
        mem_rdata = mem[mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (err_valid) begin
      ev_type.push_back(int'(err_type));
      ev_addr.push_back(int'(err_addr));
    end
    if (!mem_req && mem_we) we_bad++;
  end

  // Hamming: check bits are the XOR of the positions of all set data bits
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [5:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 3; p <= 38; p++) begin
      if ($countones(p) > 1) begin
        if (d[k]) c = c ^ p[5:0];
        k++;
      end
    end
    return {^{c, d}, c, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_random();
    for (int w = 0; w < N; w++) begin
      orig[w]  = $urandom;
      mem[w]   = enc(orig[w]);
      nflip[w] = 0;
    end
  endtask

  task automatic flip(input int w, input int b);
    mem[w][b] = ~mem[w][b];
    nflip[w]++;
  endtask

  task automatic start_pass();
    for (int w = 0; w < N; w++) pre[w] = mem[w];
    wr_q.delete();
    ev_type.delete();
    ev_addr.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_rd(input string tag, input int a, input bit wr);
    int n = 0;
    while (!(mem_req && (mem_we == wr) && (int'(mem_addr) == a))
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 2000), 64'd1);
  endtask

  task automatic finish_pass(input string tag, input int extra);
    int rel, nsgl, ndbl, last, bad, ei;
    int exp_wr[$];
    nsgl = 0;
    ndbl = 0;
    last = -1;
    for (int w = 0; w < N; w++) begin
      if (nflip[w] == 1) begin
        nsgl++;
        exp_wr.push_back(w);
      end
      if (nflip[w] == 2) ndbl++;
      if (nflip[w] > 0) last = w;
    end
    rel = cyc - t0 + 1;
    while (!done && rel < 3000) begin
      @(negedge clk);
      rel = cyc - t0 + 1;
    end
    chk({tag, ".done_cycle"}, 64'(rel), 64'(4 * N + 1 + nsgl + extra));
    chk({tag, ".corr"}, 64'(corr_count), 64'(nsgl));
    chk({tag, ".uncorr"}, 64'(uncorr_count), 64'(ndbl));
    @(negedge clk);
    chk({tag, ".done_pulse"}, {62'd0, done, busy}, 64'd0);
    chk({tag, ".n_writes"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    bad = 0;
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
      if (wr_q[i] != exp_wr[i]) bad++;
    end
    chk({tag, ".write_addrs"}, 64'(bad), 64'd0);
    chk({tag, ".n_events"}, 64'(ev_type.size()), 64'(nsgl + ndbl));
    bad = 0;
    ei = 0;
    for (int w = 0; w < N; w++) begin
      if (nflip[w] > 0 && ei < ev_type.size()) begin
        if (ev_addr[ei] != w) bad++;
        if (ev_type[ei] != int'(nflip[w] == 2)) bad++;
        ei++;
      end
    end
    chk({tag, ".events"}, 64'(bad), 64'd0);
    if (last >= 0) chk({tag, ".err_addr"}, 64'(err_addr), 64'(last));
    bad = 0;
    for (int w = 0; w < N; w++) begin
      if (nflip[w] == 1) begin
        if (mem[w] !== enc(orig[w])) bad++;
      end else if (mem[w] !== pre[w]) begin
        bad++;
      end
      if (nflip[w] == 1) nflip[w] = 0;
    end
    chk({tag, ".mem_image"}, 64'(bad), 64'd0);
    chk({tag, ".we_without_req"}, 64'(we_bad), 64'd0);
  endtask

  initial begin
    int sb, w, b1, b2, bad;
    logic [38:0] held;
    rst       = 1'b1;
    start     = 1'b0;
    mem_gnt   = 1'b1;
    mem_rdata = '0;
    load_random();
    #1;
    chk("reset.outs",
        {57'd0, mem_req, mem_we, busy, done, err_valid, err_type, 1'b0},
        64'd0);
    chk("reset.addr_wdata", {19'd0, mem_addr, mem_wdata}, 64'd0);
    chk("reset.log", {20'd0, err_addr, corr_count, uncorr_count}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    load_random();
    start_pass();
    chk("clean.busy", 64'(busy), 64'd1);
    finish_pass("clean", 0);

    load_random();
    orig[1] = 32'h0000_000D;
    mem[1]  = enc(orig[1]);
    flip(1, 6);
    start_pass();
    finish_pass("single", 0);
    chk("single.data", 64'(mem[1][31:0]), 64'h0000_000D);

    load_random();
    orig[1] = 32'h0000_000D;
    mem[1]  = enc(orig[1]);
    flip(1, 5);
    flip(1, 6);
    start_pass();
    finish_pass("double", 0);

    load_random();
    flip(3, 38);
    flip(7, 33);
    start_pass();
    finish_pass("parity_check", 0);

    load_random();
    flip(9, 20);
    start_pass();
    wait_rd("stall.find_rd5", 5, 1'b0);
    mem_gnt = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(mem_req && !mem_we && mem_addr == 6'd5)) bad++;
    end
    mem_gnt = 1'b1;
    chk("stall.rd_hold", 64'(bad), 64'd0);
    wait_rd("stall.find_wr9", 9, 1'b1);
    mem_gnt = 1'b0;
    held = mem_wdata;
    chk("stall.wdata", 64'(held), 64'(enc(orig[9])));
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(mem_req && mem_we && mem_addr == 6'd9 && mem_wdata == held))
        bad++;
    end
    mem_gnt = 1'b1;
    chk("stall.wr_hold", 64'(bad), 64'd0);
    finish_pass("stall", 20);

    load_random();
    flip(2, 10);
    flip(20, 3);
    start_pass();
    wait_rd("rst.find_rd20", 20, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst.outs",
        {57'd0, mem_req, mem_we, busy, done, err_valid, err_type, 1'b0},
        64'd0);
    chk("rst.addr_wdata", {19'd0, mem_addr, mem_wdata}, 64'd0);
    chk("rst.log", {20'd0, err_addr, corr_count, uncorr_count}, 64'd0);
    chk("rst.no_write20", 64'(mem[20]), 64'(pre[20]));
    chk("rst.word2_fixed", 64'(mem[2]), 64'(enc(orig[2])));
    nflip[2] = 0;
    @(negedge clk);
    rst = 1'b0;
    start_pass();
    finish_pass("after_rst", 0);

    for (int pass = 0; pass < 3; pass++) begin
      load_random();
      for (int e = 0; e < 6; e++) begin
        w = $urandom_range(N - 1);
        if (nflip[w] == 0) begin
          b1 = $urandom_range(38);
          flip(w, b1);
          if ($urandom_range(1) == 1) begin
            b2 = (b1 + 1 + $urandom_range(37)) % 39;
            flip(w, b2);
          end
        end
      end
      sb = pass;
      start_pass();
      if (sb == 1) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      finish_pass("random", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_mem_scrubber.md
Name: ecc_mem_scrubber

Overview:
- Background reader/corrector for the SECDED-protected data memory behind the pipeline's memory stage.
- On `start`, walks every word index 0..DEPTH-1 and checks each codeword.
- Single-bit error: writes the corrected codeword back.
- Double-bit error: logs it and leaves memory untouched.
- Shares the memory port with the CPU through a req/gnt handshake; the CPU-side arbiter owns `mem_gnt`.

Parameters:
- ADDR_W, 6, word-index width.
- DEPTH, 64, number of words scrubbed (≤ 2^ADDR_W).
- CNT_W, 16, width of the error counters.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; begins a pass when idle.
- mem_req  out  1  port request.
- mem_gnt  in  1  port grant; a transfer occurs on any edge where mem_req&mem_gnt.
- mem_we  out  1  1 = write transfer, 0 = read transfer.
- mem_addr  out  ADDR_W  word index.
- mem_wdata  out  39  corrected codeword.
- mem_rdata  in  39  read codeword; valid the cycle after a read transfer.
- busy  out  1  pass in progress.
- done  out  1  1-cycle pulse at end of pass.
- err_valid  out  1  1-cycle pulse when a word with an error is classified.
- err_type  out  1  0 = corrected single, 1 = uncorrectable double; valid with err_valid.
- err_addr  out  ADDR_W  index of the last erroneous word.
- corr_count  out  CNT_W  corrected errors this pass.
- uncorr_count  out  CNT_W  uncorrectable errors this pass.

Behaviour:
- Codeword layout:
  - [31:0] data d0..d31.
  - [37:32] check bits c0..c5.
  - [38] overall parity P = XOR of [37:0].
- Data mapping: d_k maps to Hamming position p_k, the k-th non-power-of-two integer ≥ 3 (3,5,6,7,9,...,38).
- Check bits: c_i = XOR of all d_k where bit i of p_k is 1.
- Decode:
  - syndrome s = recomputed c XOR stored c; pe = XOR of all 39 bits.
  - s=0, pe=0: clean.
  - pe=1, s=0: flip bit 38.
  - pe=1, s=2^i: flip c_i.
  - pe=1, s=p_k: flip d_k.
  - pe=0, s≠0: double error.
  - pe=1, s not a valid position (s>38): uncorrectable.
- FSM states: IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT, DONE.
- IDLE: start=1 → clear counters, addr=0, go to RD_REQ. start in any other state is ignored.
- RD_REQ: mem_req=1, mem_we=0. Hold until gnt, then go to RD_WAIT.
- RD_WAIT: register mem_rdata, go to CHECK.
- CHECK (decode on the registered word):
  - clean → NEXT.
  - single → err_valid=1, err_type=0, corr_count+1 (saturating), err_addr=addr, go to WR_REQ.
  - uncorrectable → err_valid=1, err_type=1, uncorr_count+1 (saturating), err_addr=addr, go to NEXT.
- WR_REQ: mem_req=1, mem_we=1, mem_wdata=corrected word. Hold until gnt, then go to NEXT.
- NEXT: if addr==DEPTH-1 go to DONE, else addr+1 and go to RD_REQ.
- DONE: done=1 for one cycle, then IDLE.
- Port rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and gnt=0.
  - mem_req is never dropped before grant.
  - mem_we=0 whenever mem_req=0.
- Timing: with gnt tied 1, a clean word takes 4 cycles and a corrected word 5. done is high in cycle 4*DEPTH+1 after the start edge on a clean memory.
- busy=1 in every state except IDLE. done and busy are never both 0 while a pass is still running.
- Counters and err_addr hold their values after DONE until the next start.
- Reset: async rst=1 forces IDLE with:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - busy=0, done=0, err_valid=0, err_type=0, err_addr=0;
  - both counters 0.
- Reset mid-pass aborts with no partial write. The next start begins at index 0.

Test Plan:
- Clean pass: load 64 valid codewords, gnt=1, pulse start → 0 write transfers, done at cycle 257, corr_count=0, uncorr_count=0.
- Single data-bit error: word 1 encodes 0x0000000D, flip bit 6 → one write to addr 1 with the original codeword, err_valid with err_type=0, err_addr=1, corr_count=1; memory word 1 decodes to 0x0000000D afterwards.
- Double error: flip bits 5 and 6 of word 1 → no write, err_type=1, err_addr=1, uncorr_count=1, word 1 unchanged.
- Parity/check-bit errors: flip bit 38 of word 3 and bit 33 of word 7 → two corrective writes to 3 and 7, corr_count=2, err_addr=7 at end.
- Stall: hold gnt=0 for 10 cycles during RD_REQ of word 5, then during WR_REQ of a corrected word → mem_req held, addr/wdata stable, no word skipped, done delayed by exactly 20 cycles.
- Reset mid-pass: assert rst while at word 20 → all outputs 0 immediately, no write occurs; a new start scrubs from index 0 and completes normally.
